// File: rtl/controle_entrada.sv
// controle_entrada: user-input handshake for a processor input instruction.
// A raw push-button is synchronized and debounced; a clean press latches the
// switch value and hands it to the processor with a one-cycle DadoValido
// pulse, while Stall freezes the processor during the wait.
module controle_entrada #(
  parameter int unsigned DEBOUNCE_CYCLES = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqEntrada,
  input  logic        Botao,
  input  logic [13:0] Sw,
  output logic [31:0] DadoEntrada,
  output logic        DadoValido,
  output logic        Stall,
  output logic        Rejeitado,
  output logic        Aguardando
);

  // FSM encoding kept as plain constants for compatibility with older flows.
  localparam logic [2:0] OCIOSO        = 3'd0;
  localparam logic [2:0] ESPERA_SOLTAR = 3'd1;
  localparam logic [2:0] ESPERA_APERTO = 3'd2;
  localparam logic [2:0] ENTREGA       = 3'd3;
  localparam logic [2:0] ESPERA_FIM    = 3'd4;

  // The counter is 16 bits wide, enough for the largest legal debounce length.
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES);

  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic        aperto_prev_q;
  logic        aperto, evento;
  logic [2:0]  state_q, state_d;
  logic [31:0] dado_q, dado_d;
  logic        rej_q, rej_d;

  // Two-flop synchronizer; resets to the released (high) level of the button.
  always_ff @(posedge Clock) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two sync stages.
    if (Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= Botao;
      sync2_q <= sync1_q;
    end
  end

  // Debounce counter: counts synchronized-low cycles, saturates, clears on high.
  always_comb begin
    // NOTE: a default assignment first means every path drives cnt_d, so no
    // latch is inferred when the saturation branch leaves it untouched.
    cnt_d = cnt_q;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // A press is "held" while saturated; the event is the first saturated cycle.
  assign aperto = (cnt_q == CNT_MAX);
  assign evento = aperto && !aperto_prev_q;

  // Request protocol: wait for release/press, latch the value, hand it over.
  always_comb begin
    state_d = state_q;
    dado_d  = dado_q;
    rej_d   = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (ReqEntrada) begin
          // A button already held when the request arrives must be released first.
          state_d = aperto ? ESPERA_SOLTAR : ESPERA_APERTO;
        end
      end
      ESPERA_SOLTAR: begin
        if (!ReqEntrada) begin
          state_d = OCIOSO;
        end else if (cnt_q == '0) begin
          state_d = ESPERA_APERTO;
        end
      end
      ESPERA_APERTO: begin
        // Abort wins over a press landing in the same cycle.
        if (!ReqEntrada) begin
          state_d = OCIOSO;
        end else if (evento) begin
          if (Sw[13]) begin
            dado_d  = {19'd0, Sw[12:0]};
            state_d = ENTREGA;
          end else begin
            rej_d   = 1'b1;
            state_d = ESPERA_SOLTAR;
          end
        end
      end
      ENTREGA: begin
        state_d = ESPERA_FIM;
      end
      ESPERA_FIM: begin
        // Only a dropped request re-arms, so a held request yields one value.
        if (!ReqEntrada) begin
          state_d = OCIOSO;
        end
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  // State, counter, latched value and reject pulse registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q         <= '0;
      aperto_prev_q <= 1'b0;
      state_q       <= OCIOSO;
      dado_q        <= '0;
      rej_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      aperto_prev_q <= aperto;
      state_q       <= state_d;
      dado_q        <= dado_d;
      rej_q         <= rej_d;
    end
  end

  assign DadoEntrada = dado_q;
  assign DadoValido  = (state_q == ENTREGA);
  assign Rejeitado   = rej_q;
  assign Aguardando  = (state_q == ESPERA_SOLTAR) || (state_q == ESPERA_APERTO);
  // Stall rises combinationally in the request cycle itself.
  assign Stall       = ((state_q == OCIOSO) && ReqEntrada) || Aguardando;

endmodule
